// File: rtl/onn_phase_sequencer.sv
// onn_phase_sequencer: run controller issuing reset, drop and periodic check pulses to the ONN phase registers.
// Define ONN_CHG_MASK_EN to add the last_change_mask and ever_changed outputs.
module onn_phase_sequencer #(
  parameter int N_OSC = 9,
  parameter int CHECK_PERIOD = 16,
  parameter int STABLE_CHECKS = 3,
  parameter int MAX_ITER = 255
) (
  input  logic                          clk,
  input  logic                          re,
  input  logic                          start,
  input  logic                          abort,
  input  logic [N_OSC-1:0]              state_changed,
  output logic                          re_out,
  output logic                          drop_out,
  output logic                          check_out,
  output logic                          busy,
  output logic                          done,
  output logic                          converged,
  output logic                          timeout,
  output logic [7:0]                    iter_count,
  output logic [$clog2(N_OSC+1)-1:0]    change_count
`ifdef ONN_CHG_MASK_EN
  ,
  output logic [N_OSC-1:0]              last_change_mask,
  output logic [N_OSC-1:0]              ever_changed
`endif
);
  localparam int CW = $clog2(N_OSC + 1);
  localparam int SW = CHECK_PERIOD > 1 ? $clog2(CHECK_PERIOD) : 1;
  localparam int TW = $clog2(STABLE_CHECKS + 1);
  typedef enum logic [2:0] {IDLE, RST, DROP, SETTLE, CHECK, SAMPLE, DONE} state_t;
  state_t state, nxt;
  logic [SW-1:0] settle, settle_d;
  logic [TW-1:0] stable, stable_d, stable_nxt;
  logic [CW-1:0] pop, chg_d;
  logic [7:0] iter_d, iter_nxt;
  logic re_d, drop_d, check_d, busy_d, done_d, conv_d, tmo_d;
  logic launch, hit_conv, hit_max;
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_OSC; i++) pop = pop + CW'(state_changed[i]);
    stable_nxt = (pop == '0) ? stable + 1'b1 : '0;
    iter_nxt = iter_count + 8'd1;
    hit_conv = (pop == '0) && (stable_nxt == TW'(STABLE_CHECKS));
    hit_max = iter_nxt == 8'(MAX_ITER);
    launch = (state == IDLE || state == DONE) && start;
  end
  always_comb begin
    nxt = state;
    if (abort) nxt = IDLE;
    else
      case (state)
        IDLE, DONE: nxt = start ? RST : state;
        RST:        nxt = DROP;
        DROP:       nxt = SETTLE;
        SETTLE:     nxt = (settle == '0) ? CHECK : SETTLE;
        CHECK:      nxt = SAMPLE;
        SAMPLE:     nxt = (hit_conv || hit_max) ? DONE : SETTLE;
        default:    nxt = IDLE;
      endcase
  end
  // Outputs are computed from the next state so each one lands in a flop.
  always_comb begin
    re_d = nxt == RST;
    drop_d = nxt == DROP;
    check_d = nxt == CHECK;
    busy_d = !(nxt == IDLE || nxt == DONE);
    done_d = nxt == DONE;
    settle_d = settle;
    stable_d = stable;
    iter_d = iter_count;
    chg_d = change_count;
    conv_d = converged;
    tmo_d = timeout;
    if (abort) begin
      conv_d = 1'b0;
      tmo_d = 1'b0;
    end else if (launch) begin
      stable_d = '0;
      iter_d = '0;
      chg_d = '0;
      conv_d = 1'b0;
      tmo_d = 1'b0;
    end else if (state == DROP) begin
      settle_d = SW'(CHECK_PERIOD - 1);
    end else if (state == SETTLE) begin
      settle_d = settle - SW'(settle != '0);
    end else if (state == SAMPLE) begin
      settle_d = SW'(CHECK_PERIOD - 1);
      stable_d = stable_nxt;
      iter_d = iter_nxt;
      chg_d = pop;
      conv_d = hit_conv;
      tmo_d = !hit_conv && hit_max;
    end
  end
  always_ff @(posedge clk or posedge re)
    if (re) begin
      state <= IDLE;
      settle <= '0;
      stable <= '0;
      re_out <= 1'b0;
      drop_out <= 1'b0;
      check_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      converged <= 1'b0;
      timeout <= 1'b0;
      iter_count <= '0;
      change_count <= '0;
    end else begin
      state <= nxt;
      settle <= settle_d;
      stable <= stable_d;
      re_out <= re_d;
      drop_out <= drop_d;
      check_out <= check_d;
      busy <= busy_d;
      done <= done_d;
      converged <= conv_d;
      timeout <= tmo_d;
      iter_count <= iter_d;
      change_count <= chg_d;
    end
`ifdef ONN_CHG_MASK_EN
  always_ff @(posedge clk or posedge re)
    if (re) begin
      last_change_mask <= '0;
      ever_changed <= '0;
    end else if (!abort) begin
      if (state == SAMPLE) begin
        last_change_mask <= state_changed;
        ever_changed <= ever_changed | state_changed;
      end else if (launch) ever_changed <= '0;
    end
`endif
endmodule

// File: tb/tb_onn_phase_sequencer.sv
// tb_onn_phase_sequencer: scoreboard bench; stimulus queues timed snapshots and run results, a monitor compares.
module tb_onn_phase_sequencer;
  logic clk = 1'b0, re, start, abort;
  logic [3:0] state_changed;
  logic re_out, drop_out, check_out, busy, done, converged, timeout;
  logic [7:0] iter_count;
  logic [2:0] change_count;
`ifdef ONN_CHG_MASK_EN
  logic [3:0] last_change_mask, ever_changed;
`endif
  onn_phase_sequencer #(.N_OSC(4), .CHECK_PERIOD(4), .STABLE_CHECKS(2), .MAX_ITER(5)) dut (
    .clk(clk), .re(re), .start(start), .abort(abort), .state_changed(state_changed),
    .re_out(re_out), .drop_out(drop_out), .check_out(check_out), .busy(busy), .done(done),
    .converged(converged), .timeout(timeout), .iter_count(iter_count), .change_count(change_count)
`ifdef ONN_CHG_MASK_EN
    , .last_change_mask(last_change_mask), .ever_changed(ever_changed)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct { string tag; int at; logic [17:0] v; logic chk_m; logic [3:0] lm; logic [3:0] em; } snap_t;
  typedef struct { string tag; logic cv; logic to; logic [7:0] it; logic [2:0] ch; int nc; } res_t;
  snap_t sq[$];
  res_t rq[$];
  logic [3:0] pat[$];
  int b, n_cmp = 0, n_fail = 0, to_cnt = 0, to_seen = 0, nchk = 0;
  logic fin = 1'b0, done_q = 1'b0;
  function automatic logic [17:0] sv(input logic r, d, c, bs, dn, cv, to, input logic [7:0] it, input logic [2:0] ch);
    return {r, d, c, bs, dn, cv, to, it, ch};
  endfunction
  task automatic push(input string t, input int k, input logic [17:0] v);
    sq.push_back('{t, b + k - 1, v, 1'b0, 4'd0, 4'd0});
  endtask
  task automatic pushm(input string t, input int k, input logic [17:0] v, input logic [3:0] lm, input logic [3:0] em);
    sq.push_back('{t, b + k - 1, v, 1'b1, lm, em});
  endtask
  task automatic begin_run();
    @(negedge clk);
    b = cyc + 1;
    start = 1'b1;
  endtask
  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done) to_cnt++;
  endtask
  // Models the phase registers: a new state_changed value appears after each check pulse.
  always @(negedge clk)
    if (check_out) state_changed = pat.size() > 0 ? pat.pop_front() : 4'd0;
  always @(negedge clk) begin
    snap_t s;
    res_t r;
    logic [17:0] got;
    got = {re_out, drop_out, check_out, busy, done, converged, timeout, iter_count, change_count};
    if (re_out) nchk = 0;
    if (check_out) nchk++;
    if (re_out | drop_out | check_out) begin
      n_cmp++;
      if (int'(re_out) + int'(drop_out) + int'(check_out) != 1) begin
        n_fail++;
        $display("FAIL pulse_excl @cyc %0d: got re/drop/chk=%b%b%b, want exactly one high", cyc, re_out, drop_out, check_out);
      end
    end
    while (sq.size() > 0 && sq[0].at <= cyc) begin
      s = sq.pop_front();
      n_cmp++;
      if (s.at < cyc) begin
        n_fail++;
        $display("FAIL %s: snapshot for cyc %0d not taken (now %0d)", s.tag, s.at, cyc);
      end else if (got !== s.v) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got pulses/busy/done/conv/tmo=%b iter=%0d chg=%0d, want %b iter=%0d chg=%0d",
                 s.tag, cyc, got[17:11], got[10:3], got[2:0], s.v[17:11], s.v[10:3], s.v[2:0]);
      end
`ifdef ONN_CHG_MASK_EN
      else if (s.chk_m && {last_change_mask, ever_changed} !== {s.lm, s.em}) begin
        n_fail++;
        $display("FAIL %s_mask @cyc %0d: got last=%b ever=%b, want last=%b ever=%b",
                 s.tag, cyc, last_change_mask, ever_changed, s.lm, s.em);
      end
`endif
    end
    if (done && !done_q) begin
      n_cmp++;
      if (rq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done @cyc %0d: got done=1, want no run completion", cyc);
      end else begin
        r = rq.pop_front();
        if ({converged, timeout, iter_count, change_count} !== {r.cv, r.to, r.it, r.ch} || nchk != r.nc) begin
          n_fail++;
          $display("FAIL %s: got conv=%b tmo=%b iter=%0d chg=%0d checks=%0d, want conv=%b tmo=%b iter=%0d chg=%0d checks=%0d",
                   r.tag, converged, timeout, iter_count, change_count, nchk, r.cv, r.to, r.it, r.ch, r.nc);
        end
      end
    end
    done_q = done;
    if (to_cnt != to_seen) begin
      to_seen++;
      n_cmp++;
      n_fail++;
      $display("FAIL done_wait: got done=0 after 300 cycles, want 1");
    end
    if (fin) begin
      n_cmp++;
      if (sq.size() != 0 || rq.size() != 0) begin
        n_fail++;
        $display("FAIL leftover: got %0d snapshots and %0d results pending, want 0", sq.size(), rq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    re = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    state_changed = 4'd0;
    repeat (3) @(negedge clk);
    re = 1'b0;
    b = cyc + 1;
    pushm("reset", 1, sv(0,0,0,0,0,0,0,8'd0,3'd0), 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    // all-stable run: converges after two checks
    pat = {};
    begin_run();
    push("t1_re", 1, sv(1,0,0,1,0,0,0,8'd0,3'd0));
    push("t1_drop", 2, sv(0,1,0,1,0,0,0,8'd0,3'd0));
    push("t1_settle", 3, sv(0,0,0,1,0,0,0,8'd0,3'd0));
    push("t1_pre_chk", 6, sv(0,0,0,1,0,0,0,8'd0,3'd0));
    push("t1_chk1", 7, sv(0,0,1,1,0,0,0,8'd0,3'd0));
    push("t1_smp1", 8, sv(0,0,0,1,0,0,0,8'd0,3'd0));
    push("t1_iter1", 9, sv(0,0,0,1,0,0,0,8'd1,3'd0));
    push("t1_chk2", 13, sv(0,0,1,1,0,0,0,8'd1,3'd0));
    push("t2_done", 15, sv(0,0,0,0,1,1,0,8'd2,3'd0));
    rq.push_back('{"t2_conv", 1'b1, 1'b0, 8'd2, 3'd0, 2});
    release_start();
    wait_done();
    // never two consecutive stable checks: times out at MAX_ITER
    pat = {4'b1011, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
    begin_run();
    push("t3_clear", 1, sv(1,0,0,1,0,0,0,8'd0,3'd0));
    push("t3_s1", 9, sv(0,0,0,1,0,0,0,8'd1,3'd3));
    push("t3_s2", 15, sv(0,0,0,1,0,0,0,8'd2,3'd1));
    push("t3_s3", 21, sv(0,0,0,1,0,0,0,8'd3,3'd0));
    push("t3_s4", 27, sv(0,0,0,1,0,0,0,8'd4,3'd1));
    push("t3_done", 33, sv(0,0,0,0,1,0,1,8'd5,3'd0));
    rq.push_back('{"t3_tmo", 1'b0, 1'b1, 8'd5, 3'd0, 5});
    release_start();
    wait_done();
    pat = {4'b0100, 4'b0000, 4'b0000};
    begin_run();
    push("t4_clear", 1, sv(1,0,0,1,0,0,0,8'd0,3'd0));
    push("t4_s1", 9, sv(0,0,0,1,0,0,0,8'd1,3'd1));
    push("t4_done", 21, sv(0,0,0,0,1,1,0,8'd3,3'd0));
    rq.push_back('{"t4_conv", 1'b1, 1'b0, 8'd3, 3'd0, 3});
    release_start();
    wait_done();
    // restart from DONE, then abort in the second settle window
    pat = {4'b0110};
    begin_run();
    push("t4_restart", 1, sv(1,0,0,1,0,0,0,8'd0,3'd0));
    push("t5_s1", 9, sv(0,0,0,1,0,0,0,8'd1,3'd2));
    push("t5_abort", 11, sv(0,0,0,0,0,0,0,8'd1,3'd2));
    push("t5_no_chk", 13, sv(0,0,0,0,0,0,0,8'd1,3'd2));
    release_start();
    wait_cyc(b + 9);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_cyc(b + 13);
    // start while busy is ignored; async reset in the middle of a check pulse
    pat = {4'b0001, 4'b1000, 4'b0000};
    begin_run();
    pushm("t6_launch", 1, sv(1,0,0,1,0,0,0,8'd0,3'd0), 4'b0110, 4'b0000);
    push("t6_start_ign", 6, sv(0,0,0,1,0,0,0,8'd0,3'd0));
    push("t6_chk1", 7, sv(0,0,1,1,0,0,0,8'd0,3'd0));
    push("t6_chk2", 13, sv(0,0,1,1,0,0,0,8'd1,3'd1));
    pushm("t6_s2", 15, sv(0,0,0,1,0,0,0,8'd2,3'd1), 4'b1000, 4'b1001);
    pushm("t6_re", 19, sv(0,0,0,0,0,0,0,8'd0,3'd0), 4'd0, 4'd0);
    pushm("t6_post_re", 21, sv(0,0,0,0,0,0,0,8'd0,3'd0), 4'd0, 4'd0);
    release_start();
    wait_cyc(b + 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(b + 17);
    @(posedge clk);
    #2 re = 1'b1;
    repeat (3) @(negedge clk);
    re = 1'b0;
    repeat (3) @(negedge clk);
    fin = 1'b1;
    forever @(negedge clk);
  end
endmodule
